gpio_ctrl: RTL and testbench

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_pkg.sv | 18 +
 rtl/gpio_ctrl_sync_2ff.sv | 37 +++
 rtl/gpio_ctrl.sv | 177 +++++++++++++++++
 tb/tb_gpio_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared constants and FSM encoding for gpio_ctrl
// Purpose: register index constants and bus FSM state type used by gpio_ctrl.
// Ports: none (package).
package gpio_pkg;

    localparam logic [2:0] GPIO_OUT  = 3'd0;
    localparam logic [2:0] GPIO_DIR  = 3'd1;
    localparam logic [2:0] GPIO_IN   = 3'd2;
    localparam logic [2:0] GPIO_EDGE = 3'd3;
    localparam logic [2:0] GPIO_MASK = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/gpio_ctrl_sync_2ff.sv
// rtl/gpio_ctrl_sync_2ff.sv - two-flop input synchronizer
// Purpose: bring asynchronous pin inputs into the clk domain.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, clears both stages
//   d    - asynchronous input bits
//   q    - synchronized output, two cycles behind d
module sync_2ff #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO register block with simple req/ack CPU bus
// Purpose: OUT/DIR/IN registers, optional rising-edge capture and masked irq.
// Optional feature macro: GPIO_IRQ_EN (EDGE/MASK registers and irq logic).
// Ports:
//   clk, rst         - clock and asynchronous active-high reset
//   req, we, addr    - bus request, write enable, register index
//   wdata, rdata     - write data, read data (valid while ack=1)
//   ack              - one-cycle completion pulse
//   gpio_i           - asynchronous pin inputs
//   gpio_o, gpio_oe  - OUT and DIR register values
//   irq              - registered level interrupt
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int          WIDTH   = 32,
    parameter logic [31:0] RST_OUT = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ack,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] in_sync;
    logic [31:0]      rd_val;
    logic             wr_en;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_i),
        .q   (in_sync)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs: rdata is forced to zero outside the response cycle
    always_comb begin
        ack   = (state_q == ST_RESP);
        rdata = ack ? rdata_q : 32'h0;
    end

    // Request fields are only captured in IDLE, so bus changes mid-transaction are ignored
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_q == ST_IDLE && req) begin
            we_d    = we;
            addr_d  = addr;
            wdata_d = wdata;
        end
    end

    assign wr_en = (state_q == ST_ACCESS) && we_q;

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (wr_en && addr_q == GPIO_OUT) out_d = wdata_q[WIDTH-1:0];
        if (wr_en && addr_q == GPIO_DIR) dir_d = wdata_q[WIDTH-1:0];
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rise, w1c;
    logic [1:0]       arm_q, arm_d;
    logic             irq_q, irq_d;

    // Edge capture stays disarmed until the synchronizer and prev stage hold real
    // pin values, so pins already high at reset release do not look like rises.
    always_comb begin
        arm_d  = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
        prev_d = in_sync;
        rise   = (arm_q == 2'd3) ? (in_sync & ~prev_q) : '0;
        w1c    = (wr_en && addr_q == GPIO_EDGE) ? wdata_q[WIDTH-1:0] : '0;
        // A new rise wins over a simultaneous clear
        edge_d = (edge_q & ~w1c) | rise;
        mask_d = (wr_en && addr_q == GPIO_MASK) ? wdata_q[WIDTH-1:0] : mask_q;
        irq_d  = |(edge_q & mask_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q  <= 2'd0;
            prev_q <= '0;
            edge_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            arm_q  <= arm_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Read mux over the captured index; unused upper bits and unmapped indices read 0
    always_comb begin
        rd_val = 32'h0;
        case (addr_q)
            GPIO_OUT:  rd_val[WIDTH-1:0] = out_q;
            GPIO_DIR:  rd_val[WIDTH-1:0] = dir_q;
            GPIO_IN:   rd_val[WIDTH-1:0] = in_sync;
`ifdef GPIO_IRQ_EN
            GPIO_EDGE: rd_val[WIDTH-1:0] = edge_q;
            GPIO_MASK: rd_val[WIDTH-1:0] = mask_q;
`endif
            default:   rd_val = 32'h0;
        endcase
    end

    // Register value is sampled during ACCESS (before any write in that cycle lands)
    always_comb begin
        rdata_d = (state_q == ST_ACCESS) ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= 3'd0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            out_q   <= RST_OUT[WIDTH-1:0];
            dir_q   <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
        end
    end

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed scoreboard bench for gpio_ctrl
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic [31:0] gpio_i;
    logic [31:0] gpio_o;
    logic [31:0] gpio_oe;
    logic        irq;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    gpio_ctrl #(.WIDTH(32), .RST_OUT(32'h0)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called on a negedge; returns on the negedge where ack is seen, with req dropped.
    task automatic xfer(input string tag, input logic w, input logic [2:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
        int          lat;
        logic [31:0] e;
        if (!w) exp_q.push_back(exp_rd);
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 8);
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        if (!w) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, rdata, e);
        end
        req = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        xfer(tag, 1'b1, a, d, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] expv);
        @(negedge clk);
        xfer(tag, 1'b0, a, 32'h0, expv);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'h0;
        gpio_i = 32'h1;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_gpio_o", gpio_o, 32'h0);
        chk("rst_gpio_oe", gpio_oe, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;

        wr("wr_out", 3'd0, 32'h0000_00A5);
        chk("gpio_o_a5", gpio_o, 32'h0000_00A5);
        rd("rd_out", 3'd0, 32'h0000_00A5);
        wr("wr_dir", 3'd1, 32'hFFFF_0000);
        chk("gpio_oe", gpio_oe, 32'hFFFF_0000);
        rd("rd_dir", 3'd1, 32'hFFFF_0000);
        rd("rd_a6", 3'd6, 32'h0);
        wr("wr_a5", 3'd5, 32'h1234_5678);
        rd("rd_a5", 3'd5, 32'h0);
        rd("rd_a7", 3'd7, 32'h0);
        rd("rd_in0", 3'd2, 32'h1);
        // pin high during reset must not register as an edge
        rd("rd_edge_rst", 3'd3, 32'h0);

        // pin change in the same cycle as the read request is not yet visible
        @(negedge clk);
        gpio_i[3] = 1'b1;
        xfer("rd_in_early", 1'b0, 3'd2, 32'h0, 32'h1);
        rd("rd_in_late", 3'd2, 32'h9);

`ifdef GPIO_IRQ_EN
        rd("rd_edge8", 3'd3, 32'h8);
        wr("wr_mask", 3'd4, 32'h8);
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);
        rd("rd_mask", 3'd4, 32'h8);

        // re-arm bit3, then make its next rise coincide with the w1c ACCESS cycle
        @(negedge clk);
        gpio_i[3] = 1'b0;
        repeat (4) @(negedge clk);
        gpio_i[3] = 1'b1;
        wr("w1c_race", 3'd3, 32'h8);
        rd("rd_edge_race", 3'd3, 32'h8);
        chk("irq_race", 32'(irq), 32'd1);
        wr("w1c_alone", 3'd3, 32'h8);
        chk("irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_clear", 32'(irq), 32'd0);
        rd("rd_edge_clr", 3'd3, 32'h0);
`else
        wr("wr_mask", 3'd4, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gpio_i = (i % 2 == 0) ? 32'hFFFF_FFF0 : 32'h0000_000F;
            chk("irq_off", 32'(irq), 32'd0);
        end
        repeat (4) @(negedge clk);
        chk("irq_off_end", 32'(irq), 32'd0);
        rd("rd_edge_off", 3'd3, 32'h0);
        rd("rd_mask_off", 3'd4, 32'h0);
`endif

        // reset asserted while a write to OUT is in ACCESS
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'h0000_005A;
        @(posedge clk);
        #1;
        chk("in_access", 32'(dut.state_q), 32'd1);
        rst = 1'b1;
        #1;
        chk("fsm_idle", 32'(dut.state_q), 32'd0);
        req = 1'b0; we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_ack", 32'(ack), 32'd0);
        end
        rst = 1'b0;
        chk("rst_out", gpio_o, 32'h0);
        chk("rst_dir", gpio_oe, 32'h0);
        @(negedge clk);
        chk("post_rst_no_ack", 32'(ack), 32'd0);
        rd("rd_out_post", 3'd0, 32'h0);
        rd("rd_dir_post", 3'd1, 32'h0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
